// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MEM_AW = 10;

    // Requester identifiers; also the bit index of each port in grant vectors
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // One requester's access fields as sampled on its grant cycle
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// port that was not served last wins. Purely combinational.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_c_o
);

    // One-hot grant from the request vector and the last-served port
    always_comb begin
        gnt_c_o = 2'b00;
        case (req_i)
            2'b01: gnt_c_o[PORT_CPU] = 1'b1;
            2'b10: gnt_c_o[PORT_DMA] = 1'b1;
            2'b11: begin
                if (last_i == PORT_DMA) begin
                    gnt_c_o[PORT_CPU] = 1'b1;
                end else begin
                    gnt_c_o[PORT_DMA] = 1'b1;
                end
            end
            default: gnt_c_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data
// memory. One access per three cycles: grant (IDLE), strobe (ACCESS),
// completion pulse with registered read data (RESP).
// Optional address bounds check enabled by defining DMEM_BOUNDS_CHK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wrData,
    output logic              m_wrMem,
    output logic              m_rdMem,
    input  logic [DATA_W-1:0] m_rdData,

    output logic              err
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wrdata_q, m_wrdata_d;
    logic              m_wr_q, m_wr_d;
    logic              m_rd_q, m_rd_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        arb_gnt_c;
    logic [1:0]        gnt_c;
    mem_req_t          port0_req_c;
    mem_req_t          port1_req_c;
    mem_req_t          sel_req_c;
    logic              sel_oob_c;

    rr_arb2 u_arb (
        .req_i   ({req1, req0}),
        .last_i  (last_q),
        .gnt_c_o (arb_gnt_c)
    );

    assign port0_req_c = '{we: we0, addr: addr0, wdata: wdata0};
    assign port1_req_c = '{we: we1, addr: addr1, wdata: wdata1};
    assign sel_req_c   = arb_gnt_c[PORT_DMA] ? port1_req_c : port0_req_c;

`ifdef DMEM_BOUNDS_CHK_EN
    // Any address bit above the memory index marks the access out of range
    assign sel_oob_c = |sel_req_c.addr[ADDR_W-1:MEM_AW];
`else
    // High address bits are ignored; the memory wraps
    assign sel_oob_c = 1'b0;
`endif

    // Next-state, latching and response decode
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        oob_d      = oob_q;
        m_addr_d   = m_addr_q;
        m_wrdata_d = m_wrdata_q;
        m_wr_d     = 1'b0;
        m_rd_d     = 1'b0;
        rvalid_d   = 2'b00;
        err_d      = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        gnt_c      = 2'b00;

        case (state_q)
            IDLE: begin
                if (|arb_gnt_c) begin
                    gnt_c      = arb_gnt_c;
                    owner_d    = arb_gnt_c[PORT_DMA];
                    last_d     = arb_gnt_c[PORT_DMA];
                    we_d       = sel_req_c.we;
                    oob_d      = sel_oob_c;
                    m_addr_d   = sel_req_c.addr;
                    m_wrdata_d = sel_req_c.we ? sel_req_c.wdata : '0;
                    m_wr_d     = sel_req_c.we & ~sel_oob_c;
                    m_rd_d     = ~sel_req_c.we & ~sel_oob_c;
                    state_d    = ACCESS;
                end
            end

            ACCESS: begin
                // Reads capture memory data (zero when out of range); writes keep rdata
                if (!we_q) begin
                    if (owner_q == PORT_DMA) begin
                        rdata1_d = oob_q ? '0 : m_rdData;
                    end else begin
                        rdata0_d = oob_q ? '0 : m_rdData;
                    end
                end
                if (owner_q == PORT_DMA) begin
                    rvalid_d[PORT_DMA] = 1'b1;
                end else begin
                    rvalid_d[PORT_CPU] = 1'b1;
                end
                err_d   = oob_q;
                state_d = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= (FIRST_PRIO == 0) ? PORT_DMA : PORT_CPU;
            owner_q    <= PORT_CPU;
            we_q       <= 1'b0;
            oob_q      <= 1'b0;
            m_addr_q   <= '0;
            m_wrdata_q <= '0;
            m_wr_q     <= 1'b0;
            m_rd_q     <= 1'b0;
            rvalid_q   <= 2'b00;
            err_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            oob_q      <= oob_d;
            m_addr_q   <= m_addr_d;
            m_wrdata_q <= m_wrdata_d;
            m_wr_q     <= m_wr_d;
            m_rd_q     <= m_rd_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Grants are issued in the same cycle the request is seen
    assign gnt0     = gnt_c[PORT_CPU];
    assign gnt1     = gnt_c[PORT_DMA];
    assign rvalid0  = rvalid_q[PORT_CPU];
    assign rvalid1  = rvalid_q[PORT_DMA];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign m_addr   = m_addr_q;
    assign m_wrData = m_wrdata_q;
    assign m_wrMem  = m_wr_q;
    assign m_rdMem  = m_rd_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

`ifdef DMEM_BOUNDS_CHK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] m_addr, m_wrData, m_rdData;
    logic        m_wrMem, m_rdMem, err;

    logic        mem_init = 1'b0;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] prev_rd [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .m_addr(m_addr), .m_wrData(m_wrData), .m_wrMem(m_wrMem),
        .m_rdMem(m_rdMem), .m_rdData(m_rdData), .err(err)
    );

    // Memory: combinational read, write on strobe; preloaded while mem_init
    assign m_rdData = mem[m_addr[9:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= (i == 5) ? 32'hDEADBEEF : {16'hA000, 16'(i)};
        end else if (m_wrMem) begin
            mem[m_addr[9:0]] <= m_wrData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_rd[0] = '0;
        prev_rd[1] = '0;
    endtask

    // One complete access from IDLE, checking every phase
    task automatic do_access(input logic p, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd);
        logic        oob;
        logic [31:0] exp_q;
        oob = BOUNDS_EN && (a[31:10] != 22'd0);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        @(negedge clk);
        chk("gnt_own",     p ? gnt1 : gnt0, 1);
        chk("gnt_other",   p ? gnt0 : gnt1, 0);
        chk("strobe_idle", {m_wrMem, m_rdMem}, 0);
        step();
        // fields must have been sampled on the grant cycle only
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 32'hFFFF_FFFF; addr1 = 32'hFFFF_FFFF; wdata0 = ~d; wdata1 = ~d;
        @(negedge clk);
        chk("m_wrMem",       m_wrMem, w && !oob);
        chk("m_rdMem",       m_rdMem, !w && !oob);
        chk("m_addr",        m_addr, a);
        chk("m_wrData",      m_wrData, w ? d : 32'd0);
        chk("rvalid_access", {rvalid0, rvalid1}, 0);
        step();
        @(negedge clk);
        exp_q = w ? prev_rd[p] : exp_rd;
        chk("rvalid_own",   p ? rvalid1 : rvalid0, 1);
        chk("rvalid_other", p ? rvalid0 : rvalid1, 0);
        chk("rdata",        p ? rdata1 : rdata0, exp_q);
        chk("err",          err, oob);
        chk("strobe_resp",  {m_wrMem, m_rdMem}, 0);
        prev_rd[p] = exp_q;
        step();
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'($urandom_range(0, 1023));
    endfunction

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    logic [1:0]  eg, erv;
    logic        win, mlast, ewr, erd, eerr;
    bit          pv;
    int          pt;
    logic        pp, pwe, poob;
    logic [31:0] pa, pd, pexp;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h005, 32'h0,          32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h3FF, 32'h12345678,   32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h3FF, 32'h0,          32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h000, 32'hCAFEF00D,   32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h005, 32'h0,          32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 32'h401, 32'h11111111,   32'h0};
`ifdef DMEM_BOUNDS_CHK_EN
        vecs[4] = '{1'b0, 1'b0, 32'h400, 32'h0,          32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h001, 32'h0,          32'hA0000001};
`else
        vecs[4] = '{1'b0, 1'b0, 32'h400, 32'h0,          32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'h001, 32'h0,          32'h11111111};
`endif

        #2;
        mem_init = 1'b1;
        do_reset();
        mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt",    {gnt0, gnt1}, 0);
        chk("rst_rvalid", {rvalid0, rvalid1}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wrd",  m_wrData, 0);
        chk("rst_strobe", {m_wrMem, m_rdMem}, 0);
        chk("rst_err",    err, 0);
        step();

        // Directed vector table
        foreach (vecs[i])
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Reset asserted during ACCESS
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(negedge clk);
        chk("mr_gnt0", gnt0, 1);
        step();
        req0 = 1'b0;
        @(negedge clk);
        chk("mr_rdMem_before", m_rdMem, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_strobe_drop", {m_wrMem, m_rdMem}, 0);
        step();
        @(negedge clk);
        chk("mr_no_rvalid", {rvalid0, rvalid1}, 0);
        step();
        rst_n = 1'b1;
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        @(negedge clk);
        chk("mr_no_rvalid2", {rvalid0, rvalid1}, 0);
        chk("mr_rdata0", rdata0, 0);
        step();
        do_access(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF);

        // Continuous contention after reset: 0,1,0,1 one grant per 3 cycles
        do_reset();
        we0 = 1'b0; we1 = 1'b0; addr0 = 32'd2; addr1 = 32'd3;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("ct_gnt0", gnt0, (c % 3 == 0) && ((c / 3) % 2 == 0));
            chk("ct_gnt1", gnt1, (c % 3 == 0) && ((c / 3) % 2 == 1));
            chk("ct_strobe_excl", m_wrMem & m_rdMem, 0);
            if (c % 3 == 2) begin
                if ((c / 3) % 2 == 0) begin
                    chk("ct_rvalid0", rvalid0, 1);
                    chk("ct_rdata0",  rdata0, 32'hA0000002);
                end else begin
                    chk("ct_rvalid1", rvalid1, 1);
                    chk("ct_rdata1",  rdata1, 32'hA0000003);
                end
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        mlast = 1'b1;
        pv = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = rnd_addr(); wdata0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = rnd_addr(); wdata1 = $urandom;
            end
            @(negedge clk);
            eg = 2'b00;
            if (!pv && (req0 || req1)) begin
                win   = (req0 && req1) ? ~mlast : req1;
                eg[win] = 1'b1;
                mlast = win;
                pv = 1'b1; pt = cyc; pp = win;
                pwe  = win ? we1 : we0;
                pa   = win ? addr1 : addr0;
                pd   = win ? wdata1 : wdata0;
                poob = BOUNDS_EN && (pa[31:10] != 22'd0);
            end
            chk("rnd_gnt0", gnt0, eg[0]);
            chk("rnd_gnt1", gnt1, eg[1]);
            ewr = 1'b0; erd = 1'b0; erv = 2'b00; eerr = 1'b0;
            if (pv && cyc == pt + 1) begin
                ewr = pwe && !poob;
                erd = !pwe && !poob;
                chk("rnd_m_addr",   m_addr, pa);
                chk("rnd_m_wrData", m_wrData, pwe ? pd : 32'd0);
                pexp = pwe ? prev_rd[pp] : (poob ? 32'd0 : ref_mem[pa[9:0]]);
                if (ewr) ref_mem[pa[9:0]] = pd;
            end
            if (pv && cyc == pt + 2) begin
                erv[pp] = 1'b1;
                eerr = poob;
                chk("rnd_rdata", pp ? rdata1 : rdata0, pexp);
                prev_rd[pp] = pexp;
                pv = 1'b0;
            end
            chk("rnd_wrMem",   m_wrMem, ewr);
            chk("rnd_rdMem",   m_rdMem, erd);
            chk("rnd_rvalid0", rvalid0, erv[0]);
            chk("rnd_rvalid1", rvalid1, erv[1]);
            chk("rnd_err",     err, eerr);
            step();
            if (eg[0]) req0 = 1'b0;
            if (eg[1]) req1 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
